alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor of the 16-bit combinational ALU.
- Keeps the same 16 logic and 16 arithmetic functions and generalises them to WIDTH bits.
- Adds a valid/ready handshake, registered result flags and a carry-flag chaining mode for multi-precision arithmetic.
- Sits between the register-file read port and the writeback stage of the datapath.

---
 rtl/alu_pipe.sv | 168 ++++++++++++++++
 tb/tb_alu_pipe.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined WIDTH-bit ALU with valid/ready handshake, registered
// result flags and an internal carry flag for multi-precision chaining.
module alu_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       select,
  input  logic             mode,
  input  logic             carry_in,
  input  logic             use_cflag,
  input  logic             cflag_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic [4:0]       flags,
  output logic             cflag
);

  localparam int unsigned SUM_W = WIDTH + 1;

  logic             s1_valid;
  logic             s2_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_select;
  logic             s1_mode;
  logic             s1_carry_in;
  logic             s1_use_cflag;

  logic             adv1;
  logic             adv2;

  logic [WIDTH-1:0] logic_res;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic [SUM_W-1:0] sum;
  logic             cin;
  logic [WIDTH-1:0] res;
  logic             res_carry;
  logic             res_ovf;
  logic             res_eq;
  logic             arith_load;

  // Handshake: stage 2 frees when empty or retiring, stage 1 when it can move on.
  assign adv2      = ~s2_valid | out_ready;
  assign adv1      = ~s1_valid | adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  // Stage 1: operand capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid     <= 1'b0;
      s1_a         <= '0;
      s1_b         <= '0;
      s1_select    <= 4'd0;
      s1_mode      <= 1'b0;
      s1_carry_in  <= 1'b0;
      s1_use_cflag <= 1'b0;
    end else if (adv1) begin
      s1_valid     <= in_valid;
      s1_a         <= in_a;
      s1_b         <= in_b;
      s1_select    <= select;
      s1_mode      <= mode;
      s1_carry_in  <= carry_in;
      s1_use_cflag <= use_cflag;
    end
  end

  // Bitwise functions.
  always_comb begin
    logic_res = '0;
    case (s1_select)
      4'd0:    logic_res = ~s1_a;
      4'd1:    logic_res = ~(s1_a | s1_b);
      4'd2:    logic_res = ~s1_a & s1_b;
      4'd3:    logic_res = '0;
      4'd4:    logic_res = ~(s1_a & s1_b);
      4'd5:    logic_res = ~s1_b;
      4'd6:    logic_res = s1_a ^ s1_b;
      4'd7:    logic_res = s1_a & ~s1_b;
      4'd8:    logic_res = ~s1_a | s1_b;
      4'd9:    logic_res = ~(s1_a ^ s1_b);
      4'd10:   logic_res = s1_b;
      4'd11:   logic_res = s1_a & s1_b;
      4'd12:   logic_res = '1;
      4'd13:   logic_res = s1_a | ~s1_b;
      4'd14:   logic_res = s1_a | s1_b;
      default: logic_res = s1_a;
    endcase
  end

  // Adder operand selection; every arithmetic function is X + Y + cin.
  always_comb begin
    op_x = s1_a;
    op_y = '0;
    case (s1_select)
      4'd0:    begin op_x = s1_a;          op_y = '0;           end
      4'd1:    begin op_x = s1_a | s1_b;   op_y = '0;           end
      4'd2:    begin op_x = s1_a | ~s1_b;  op_y = '0;           end
      4'd3:    begin op_x = '1;            op_y = '0;           end
      4'd4:    begin op_x = s1_a;          op_y = s1_a & ~s1_b; end
      4'd5:    begin op_x = s1_a | s1_b;   op_y = s1_a & ~s1_b; end
      4'd6:    begin op_x = s1_a;          op_y = ~s1_b;        end
      4'd7:    begin op_x = s1_a & ~s1_b;  op_y = '1;           end
      4'd8:    begin op_x = s1_a;          op_y = s1_a & s1_b;  end
      4'd9:    begin op_x = s1_a;          op_y = s1_b;         end
      4'd10:   begin op_x = s1_a | ~s1_b;  op_y = s1_a & s1_b;  end
      4'd11:   begin op_x = s1_a & s1_b;   op_y = '1;           end
      4'd12:   begin op_x = s1_a;          op_y = s1_a;         end
      4'd13:   begin op_x = s1_a | s1_b;   op_y = s1_a;         end
      4'd14:   begin op_x = s1_a | ~s1_b;  op_y = s1_a;         end
      default: begin op_x = s1_a;          op_y = '1;           end
    endcase
  end

  // Chained beats read the flag as it stands at their compute edge.
  assign cin = s1_use_cflag ? cflag : s1_carry_in;
  assign sum = SUM_W'(op_x) + SUM_W'(op_y) + SUM_W'(cin);

  always_comb begin
    res       = sum[WIDTH-1:0];
    res_carry = sum[WIDTH];
    res_ovf   = (op_x[WIDTH-1] == op_y[WIDTH-1]) && (sum[WIDTH-1] != op_x[WIDTH-1]);
    if (s1_mode) begin
      res       = logic_res;
      res_carry = 1'b0;
      res_ovf   = 1'b0;
    end
  end

  assign res_eq     = (s1_a == s1_b);
  assign arith_load = adv2 & s1_valid & ~s1_mode;

  // Stage 2: result and flags register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid  <= 1'b0;
      alu_out   <= '0;
      carry_out <= 1'b0;
      flags     <= 5'd0;
    end else if (adv2) begin
      s2_valid  <= s1_valid;
      alu_out   <= res;
      carry_out <= res_carry;
      flags     <= {res_eq, res_ovf, res[WIDTH-1], (res == '0), res_carry};
    end
  end

  // Carry flag: an arithmetic load takes priority over a clear request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cflag <= 1'b0;
    end else if (arith_load) begin
      cflag <= sum[WIDTH];
    end else if (cflag_clr) begin
      cflag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: vector table, directed handshake/chaining/reset sequences
// and randomized traffic against an arithmetic reference model.
module tb_alu_pipe;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  sel;
    logic        mode;
    logic        cin;
    logic        usec;
  } beat_t;

  typedef struct packed {
    logic [15:0] y;
    logic        c;
    logic [4:0]  f;
  } res_t;

  typedef struct packed {
    beat_t in;
    res_t  exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = 16'd0;
  logic [15:0] in_b = 16'd0;
  logic [3:0]  select = 4'd0;
  logic        mode = 1'b0;
  logic        carry_in = 1'b0;
  logic        use_cflag = 1'b0;
  logic        cflag_clr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] alu_out;
  logic        carry_out;
  logic [4:0]  flags;
  logic        cflag;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rdy_fixed = 1'b1;
  bit rdy_rand = 1'b0;

  beat_t acc_q[$];
  res_t  got_q[$];
  int    got_cyc[$];

  alu_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .select(select), .mode(mode),
    .carry_in(carry_in), .use_cflag(use_cflag), .cflag_clr(cflag_clr),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .carry_out(carry_out), .flags(flags), .cflag(cflag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #2;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // Transfers are observed mid-cycle, when inputs and outputs are settled.
  always @(negedge clk) begin
    if (rst) begin
      if (in_valid && in_ready) acc_q.push_back({in_a, in_b, select, mode, carry_in, use_cflag});
      if (out_valid && out_ready) begin
        got_q.push_back({alu_out, carry_out, flags});
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_q();
    acc_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  function automatic beat_t mk(logic [15:0] a, logic [15:0] b, logic [3:0] sel,
                               logic md, logic ci, logic uc);
    return {a, b, sel, md, ci, uc};
  endfunction

  function automatic vec_t mkv(beat_t b, logic [15:0] y, logic c, logic [4:0] f);
    return {b, y, c, f};
  endfunction

  task automatic drive(beat_t b);
    in_a = b.a; in_b = b.b; select = b.sel;
    mode = b.mode; carry_in = b.cin; use_cflag = b.usec;
  endtask

  // Offer one beat and hold it until the accept edge has passed.
  task automatic send(beat_t b);
    bit done;
    done = 1'b0;
    drive(b);
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_results(int n);
    for (int i = 0; i < 400 && got_q.size() < n; i++) step(1);
    if (got_q.size() < n) chk("result_timeout", 32'(got_q.size()), 32'(n));
  endtask

  task automatic chk_res(string name, res_t act, res_t exp);
    chk({name, "_out"}, 32'(act.y), 32'(exp.y));
    chk({name, "_carry"}, 32'(act.c), 32'(exp.c));
    chk({name, "_flags"}, 32'(act.f), 32'(exp.f));
  endtask

  // Reference: functions evaluated with plain integer arithmetic.
  function automatic res_t model(beat_t b, bit cf);
    res_t r;
    logic [15:0] a, bb, x, y;
    int unsigned s;
    int sx, sy, ss;
    bit c, v;
    a = b.a; bb = b.b;
    if (b.mode) begin
      case (b.sel)
        4'd0: r.y = ~a;          4'd1: r.y = ~(a | bb);
        4'd2: r.y = ~a & bb;     4'd3: r.y = 16'h0000;
        4'd4: r.y = ~(a & bb);   4'd5: r.y = ~bb;
        4'd6: r.y = a ^ bb;      4'd7: r.y = a & ~bb;
        4'd8: r.y = ~a | bb;     4'd9: r.y = ~(a ^ bb);
        4'd10: r.y = bb;         4'd11: r.y = a & bb;
        4'd12: r.y = 16'hFFFF;   4'd13: r.y = a | ~bb;
        4'd14: r.y = a | bb;     default: r.y = a;
      endcase
      c = 1'b0; v = 1'b0;
    end else begin
      case (b.sel)
        4'd0: begin x = a; y = 16'h0; end
        4'd1: begin x = a | bb; y = 16'h0; end
        4'd2: begin x = a | ~bb; y = 16'h0; end
        4'd3: begin x = 16'hFFFF; y = 16'h0; end
        4'd4: begin x = a; y = a & ~bb; end
        4'd5: begin x = a | bb; y = a & ~bb; end
        4'd6: begin x = a; y = ~bb; end
        4'd7: begin x = a & ~bb; y = 16'hFFFF; end
        4'd8: begin x = a; y = a & bb; end
        4'd9: begin x = a; y = bb; end
        4'd10: begin x = a | ~bb; y = a & bb; end
        4'd11: begin x = a & bb; y = 16'hFFFF; end
        4'd12: begin x = a; y = a; end
        4'd13: begin x = a | bb; y = a; end
        4'd14: begin x = a | ~bb; y = a; end
        default: begin x = a; y = 16'hFFFF; end
      endcase
      s  = 32'(x) + 32'(y) + ((b.usec ? cf : b.cin) ? 32'd1 : 32'd0);
      r.y = 16'(s);
      c  = (s > 32'd65535);
      sx = (x >= 16'h8000) ? int'(32'(x)) - 65536 : int'(32'(x));
      sy = (y >= 16'h8000) ? int'(32'(y)) - 65536 : int'(32'(y));
      ss = sx + sy + ((b.usec ? cf : b.cin) ? 1 : 0);
      v  = (ss > 32767) || (ss < -32768);
    end
    r.c = c;
    r.f = {a == bb, v, r.y[15], r.y == 16'h0, c};
    return r;
  endfunction

  vec_t  tbl[12];
  beat_t bp[3];
  bit    acc;
  int    n_acc;
  int    got0;
  bit    mc;
  res_t  er;

  initial begin
    tbl[0]  = mkv(mk(16'hF0F0, 16'hFF00, 4'd6, 1'b1, 1'b0, 1'b0), 16'h0FF0, 1'b0, 5'b00000);
    tbl[1]  = mkv(mk(16'hFFFF, 16'h0001, 4'd9, 1'b0, 1'b0, 1'b0), 16'h0000, 1'b1, 5'b00011);
    tbl[2]  = mkv(mk(16'h7FFF, 16'h0001, 4'd9, 1'b0, 1'b0, 1'b0), 16'h8000, 1'b0, 5'b01100);
    tbl[3]  = mkv(mk(16'h0005, 16'h0003, 4'd6, 1'b0, 1'b1, 1'b0), 16'h0002, 1'b1, 5'b00001);
    tbl[4]  = mkv(mk(16'h1234, 16'h1234, 4'd6, 1'b0, 1'b1, 1'b0), 16'h0000, 1'b1, 5'b10011);
    tbl[5]  = mkv(mk(16'h0001, 16'h0002, 4'd3, 1'b1, 1'b0, 1'b0), 16'h0000, 1'b0, 5'b00010);
    tbl[6]  = mkv(mk(16'h0000, 16'h0000, 4'd12, 1'b1, 1'b0, 1'b0), 16'hFFFF, 1'b0, 5'b10100);
    tbl[7]  = mkv(mk(16'h0005, 16'h0000, 4'd15, 1'b0, 1'b0, 1'b0), 16'h0004, 1'b1, 5'b00001);
    tbl[8]  = mkv(mk(16'h8000, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0), 16'h8001, 1'b0, 5'b00100);
    tbl[9]  = mkv(mk(16'h00FF, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0), 16'hFF00, 1'b0, 5'b00100);
    tbl[10] = mkv(mk(16'h8000, 16'h0000, 4'd12, 1'b0, 1'b0, 1'b0), 16'h0000, 1'b1, 5'b01011);
    tbl[11] = mkv(mk(16'h1234, 16'h1234, 4'd6, 1'b1, 1'b1, 1'b0), 16'h0000, 1'b0, 5'b10010);

    // Reset state.
    step(2);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cflag", 32'(cflag), 32'd0);
    chk("rst_out", 32'(alu_out), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    rst = 1'b1;
    step(1);

    // Latency of the first beat.
    send(tbl[0].in);
    chk("lat_early_valid", 32'(out_valid), 32'd0);
    step(1);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk_res("lat", {alu_out, carry_out, flags}, tbl[0].exp);
    step(2);

    // Vector table, one beat at a time.
    for (int i = 0; i < 12; i++) begin
      clear_q();
      send(tbl[i].in);
      wait_results(1);
      if (got_q.size() > 0) chk_res($sformatf("vec%0d", i), got_q[0], tbl[i].exp);
    end
    chk("vec_cflag", 32'(cflag), 32'd1);

    // 32-bit add through back-to-back chained beats.
    clear_q();
    send(mk(16'hFFFF, 16'h0001, 4'd9, 1'b0, 1'b0, 1'b0));
    send(mk(16'h0000, 16'h0000, 4'd9, 1'b0, 1'b0, 1'b1));
    wait_results(2);
    if (got_q.size() >= 2) begin
      chk("chain_lo", 32'(got_q[0].y), 32'h0000);
      chk("chain_lo_c", 32'(got_q[0].c), 32'd1);
      chk("chain_hi", 32'(got_q[1].y), 32'h0001);
      chk("chain_gap", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
    end
    chk("chain_cflag", 32'(cflag), 32'd0);

    // Clear coinciding with an arithmetic load: load wins, beat sees old flag.
    clear_q();
    send(mk(16'hFFFF, 16'h0001, 4'd9, 1'b0, 1'b0, 1'b0));
    wait_results(1);
    chk("clr_pre_cflag", 32'(cflag), 32'd1);
    send(mk(16'hFFFF, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1));
    cflag_clr = 1'b1;
    step(1);
    cflag_clr = 1'b0;
    chk("clr_coinc_cflag", 32'(cflag), 32'd1);
    wait_results(2);
    if (got_q.size() >= 2) begin
      chk("clr_coinc_out", 32'(got_q[1].y), 32'h0000);
      chk("clr_coinc_carry", 32'(got_q[1].c), 32'd1);
    end
    cflag_clr = 1'b1;
    step(1);
    cflag_clr = 1'b0;
    chk("clr_alone_cflag", 32'(cflag), 32'd0);

    // Backpressure: three beats offered against a stalled consumer.
    bp[0] = mk(16'd1, 16'd1, 4'd9, 1'b0, 1'b0, 1'b0);
    bp[1] = mk(16'd2, 16'd2, 4'd9, 1'b0, 1'b0, 1'b0);
    bp[2] = mk(16'd3, 16'd3, 4'd9, 1'b0, 1'b0, 1'b0);
    rdy_fixed = 1'b0;
    step(1);
    clear_q();
    n_acc = 0;
    drive(bp[0]);
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      acc = in_ready;
      if (out_valid) chk("bp_hold", 32'(alu_out), 32'd2);
      @(posedge clk);
      #2;
      if (acc) begin
        n_acc++;
        if (n_acc < 3) drive(bp[n_acc]);
      end
    end
    chk("bp_accepted", 32'(n_acc), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_no_retire", 32'(got_q.size()), 32'd0);
    rdy_fixed = 1'b1;
    for (int k = 0; k < 20 && (n_acc < 3 || got_q.size() < 3); k++) begin
      @(negedge clk);
      acc = in_ready & in_valid;
      @(posedge clk);
      #2;
      if (acc) begin
        n_acc++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("bp_results", 32'(got_q.size()), 32'd3);
    if (got_q.size() >= 3) begin
      chk("bp_r0", 32'(got_q[0].y), 32'd2);
      chk("bp_r1", 32'(got_q[1].y), 32'd4);
      chk("bp_r2", 32'(got_q[2].y), 32'd6);
      chk("bp_rate01", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
      chk("bp_rate12", 32'(got_cyc[2] - got_cyc[1]), 32'd1);
    end

    // Reset with two beats in flight.
    rdy_fixed = 1'b0;
    step(1);
    clear_q();
    send(mk(16'hFFFF, 16'h0001, 4'd9, 1'b0, 1'b0, 1'b0));
    send(mk(16'h0001, 16'h0001, 4'd9, 1'b0, 1'b0, 1'b0));
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    chk("mid_pre_cflag", 32'(cflag), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out", 32'(alu_out), 32'd0);
    chk("mid_rst_carry", 32'(carry_out), 32'd0);
    chk("mid_rst_flags", 32'(flags), 32'd0);
    chk("mid_rst_cflag", 32'(cflag), 32'd0);
    rdy_fixed = 1'b1;
    step(2);
    rst = 1'b1;
    got0 = got_q.size();
    step(5);
    chk("mid_no_stale", 32'(got_q.size()), 32'(got0));
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    chk("mid_cflag", 32'(cflag), 32'd0);

    // Randomized traffic with a random consumer.
    clear_q();
    rdy_rand = 1'b1;
    for (int i = 0; i < 200; i++) begin
      beat_t rb;
      rb.a    = 16'($urandom);
      rb.b    = ($urandom_range(0, 3) == 0) ? rb.a : 16'($urandom);
      rb.sel  = 4'($urandom);
      rb.mode = 1'($urandom);
      rb.cin  = 1'($urandom);
      rb.usec = 1'($urandom);
      send(rb);
      step($urandom_range(0, 1));
    end
    wait_results(200);
    rdy_rand = 1'b0;
    mc = 1'b0;
    for (int i = 0; i < 200 && i < got_q.size() && i < acc_q.size(); i++) begin
      er = model(acc_q[i], mc);
      if (!acc_q[i].mode) mc = er.c;
      chk_res($sformatf("rnd%0d", i), got_q[i], er);
    end
    chk("rnd_count", 32'(got_q.size()), 32'd200);
    step(2);
    chk("rnd_cflag", 32'(cflag), 32'(mc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
